// File: rtl/vip_bch_encoder_if.sv
// Stream bundle for the BCH encoder: message input side (s_*) and codeword
// output side (m_*). The slave modport is the encoder's view, the master
// modport is the view of whatever drives messages and sinks codewords.
interface vip_bch_encoder_if #(
  parameter int W = 1
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/vip_bch_encoder.sv
// Systematic binary BCH encoder over GF(2^M).
// The K-bit message streams through unchanged as K/W words of W bits, then
// PAR = M*T parity bits follow, computed by a W-bit-parallel LFSR that divides
// x^PAR * m(x) by the generator polynomial g(x).
// Optional build macro VIP_BCH_ENCODER_ERR_INJ_EN adds inj_en/inj_mask ports
// that flip output bits at launch time while the LFSR keeps the clean data.
module vip_bch_encoder #(
  parameter int               M        = 4,
  parameter int               T        = 2,
  parameter int               K        = 7,
  parameter int               W        = 1,
  parameter logic [M*T-1:0]   GEN_POLY = 8'hD1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vip_bch_encoder_if.slave        bus,
  output logic                    frame_err,
  output logic                    busy
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
  ,
  input  logic                    inj_en,
  input  logic [W-1:0]            inj_mask
`endif
);

  localparam int PAR      = M * T;
  localparam int N_MSG    = K / W;
  localparam int N_PAR    = PAR / W;
  localparam int MAX_BITS = (K > PAR) ? K : PAR;
  localparam int CW       = $clog2(MAX_BITS / W + 1);

  // Parameter legality is decided at elaboration; an illegal code never builds.
  if (M < 3 || M > 16) begin : g_bad_m
    $fatal(1, "vip_bch_encoder: M=%0d outside 3..16", M);
  end
  if (PAR >= (1 << M) - 1) begin : g_bad_t
    $fatal(1, "vip_bch_encoder: M*T=%0d must be below 2^M-1", PAR);
  end
  if (K < 1 || K > (1 << M) - 1 - PAR) begin : g_bad_k
    $fatal(1, "vip_bch_encoder: K=%0d outside 1..2^M-1-M*T", K);
  end
  if (W < 1 || (K % W) != 0 || (PAR % W) != 0) begin : g_bad_w
    $fatal(1, "vip_bch_encoder: W=%0d must divide K=%0d and PAR=%0d", W, K, PAR);
  end
  if ($bits(bus.s_data) != W) begin : g_bad_if
    $fatal(1, "vip_bch_encoder: interface width differs from W=%0d", W);
  end

  typedef enum logic [0:0] {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PAR-1:0]   lfsr_q, lfsr_d;
  logic             m_valid_q, m_valid_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             frame_err_q, frame_err_d;

  logic             out_free;
  logic             s_ready_c;
  logic             launch;
  logic [W-1:0]     launch_data;
  logic [W-1:0]     inj_word;

  // W serial LFSR steps folded into one cycle, highest-order data bit first.
  function automatic logic [PAR-1:0] lfsr_advance(input logic [PAR-1:0] cur,
                                                  input logic [W-1:0]   din);
    logic [PAR-1:0] s;
    logic           fb;
    s = cur;
    for (int i = W - 1; i >= 0; i--) begin
      fb = din[i] ^ s[PAR-1];
      s  = (s << 1) ^ (fb ? GEN_POLY : '0);
    end
    return s;
  endfunction

  // Error pattern applied to the outgoing word only, never fed to the LFSR.
  always_comb begin
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
    inj_word = inj_en ? inj_mask : '0;
`else
    inj_word = '0;
`endif
  end

  // Next-state logic: pass message words, then drain parity, honouring backpressure.
  always_comb begin
    out_free    = !m_valid_q || bus.m_ready;
    s_ready_c   = 1'b0;
    launch      = 1'b0;
    launch_data = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_err_d = frame_err_q;

    case (state_q)
      ST_MSG: begin
        s_ready_c = out_free;
        if (bus.s_valid && out_free) begin
          launch      = 1'b1;
          launch_data = bus.s_data;
          m_last_d    = 1'b0;
          lfsr_d      = lfsr_advance(lfsr_q, bus.s_data);
          if (bus.s_last != (cnt_q == CW'(N_MSG - 1))) begin
            frame_err_d = 1'b1;
          end
          if (cnt_q == CW'(N_MSG - 1)) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (out_free) begin
          launch      = 1'b1;
          launch_data = lfsr_q[PAR-1 -: W];
          lfsr_d      = lfsr_q << W;
          if (cnt_q == CW'(N_PAR - 1)) begin
            m_last_d = 1'b1;
            state_d  = ST_MSG;
            cnt_d    = '0;
            lfsr_d   = '0;
          end else begin
            m_last_d = 1'b0;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
    endcase

    if (launch) begin
      m_valid_d = 1'b1;
      m_data_d  = launch_data ^ inj_word;
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State, LFSR and output register; reset discards any partial codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MSG;
      cnt_q       <= '0;
      lfsr_q      <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != ST_MSG) || (cnt_q != '0);

endmodule

// File: tb/tb_vip_bch_encoder.sv
// Self-checking bench for vip_bch_encoder. Two instances: a bit-serial
// (15,7) code and a 5-bit-wide lane with a 10-bit generator. Expected
// codewords come from a polynomial long-division model of x^PAR*m(x) mod g(x).
module tb_vip_bch_encoder;

  localparam int          M0     = 4;
  localparam int          T0     = 2;
  localparam int          K0     = 7;
  localparam int          W0     = 1;
  localparam int          PAR0   = M0 * T0;
  localparam logic [7:0]  GEN0   = 8'hD1;
  localparam int          N_MSG0 = K0 / W0;
  localparam int          CWB0   = K0 + PAR0;

  localparam int          M1     = 5;
  localparam int          T1     = 2;
  localparam int          K1     = 5;
  localparam int          W1     = 5;
  localparam int          PAR1   = M1 * T1;
  localparam logic [9:0]  GEN1   = 10'h137;

  logic clk;
  logic rst_n;
  logic frame_err0, busy0, frame_err1, busy1;
  int   checks;
  int   failures;

  vip_bch_encoder_if #(.W(W0)) bus0 ();
  vip_bch_encoder_if #(.W(W1)) bus1 ();

`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
  logic          inj_en0, inj_en1;
  logic [W0-1:0] inj_mask0;
  logic [W1-1:0] inj_mask1;
`endif

  vip_bch_encoder #(.M(M0), .T(T0), .K(K0), .W(W0), .GEN_POLY(GEN0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .frame_err (frame_err0),
    .busy      (busy0)
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
    ,
    .inj_en    (inj_en0),
    .inj_mask  (inj_mask0)
`endif
  );

  vip_bch_encoder #(.M(M1), .T(T1), .K(K1), .W(W1), .GEN_POLY(GEN1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .frame_err (frame_err1),
    .busy      (busy1)
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
    ,
    .inj_en    (inj_en1),
    .inj_mask  (inj_mask1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of x^par * msg(x) divided by x^par + gen(x), by long division.
  function automatic logic [63:0] ref_parity(input logic [63:0] msg, input int k,
                                             input int par, input logic [63:0] gen);
    logic [127:0] rem, g;
    rem = {64'b0, msg} << par;
    g   = {64'b0, gen} | (128'b1 << par);
    for (int d = k + par - 1; d >= par; d--) begin
      if (rem[d]) rem = rem ^ (g << (d - par));
    end
    return rem[63:0];
  endfunction

  function automatic logic [CWB0-1:0] ref_cw0(input logic [K0-1:0] msg);
    logic [63:0] p;
    p = ref_parity({57'b0, msg}, K0, PAR0, {56'b0, GEN0});
    return {msg, p[PAR0-1:0]};
  endfunction

  // Streams one message into dut0 and collects beats until m_last or a bound.
  task automatic run_frame0(input logic [K0-1:0] msg, input int ready_pct, input int valid_pct,
                            input int last_word, input int inj_word, input int stop_after,
                            output logic [CWB0-1:0] cw, output int nbeats, output bit saw_last,
                            output int acc_cyc, output int beat_cyc0, output int beat_cyc_last,
                            output int stall_bad, output bit timeout);
    int            idx;
    int            cyc;
    bit            held;
    logic [W0-1:0] hd;
    logic          hl;
    cw = '0; nbeats = 0; saw_last = 0; acc_cyc = -1; beat_cyc0 = -1; beat_cyc_last = -1;
    stall_bad = 0; timeout = 0; idx = 0; cyc = 0; held = 0; hd = '0; hl = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (held && !(bus0.m_valid === 1'b1 && bus0.m_data === hd && bus0.m_last === hl)) stall_bad++;
      bus0.m_ready = ($urandom_range(99) < ready_pct);
      if (idx < N_MSG0 && $urandom_range(99) < valid_pct) begin
        bus0.s_valid = 1'b1;
        bus0.s_data  = msg[K0-1-idx];
        bus0.s_last  = (idx == last_word);
      end else begin
        bus0.s_valid = 1'b0;
        bus0.s_data  = '0;
        bus0.s_last  = 1'b0;
      end
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
      inj_en0   = bus0.s_valid && (idx == inj_word);
      inj_mask0 = '1;
`else
      if (inj_word > CWB0) bus0.s_last = bus0.s_last;
`endif
      #1;
      if (bus0.s_valid && bus0.s_ready) begin
        if (idx == 0) acc_cyc = cyc;
        idx++;
      end
      held = bus0.m_valid && !bus0.m_ready;
      hd   = bus0.m_data;
      hl   = bus0.m_last;
      if (bus0.m_valid && bus0.m_ready) begin
        if (nbeats == 0) beat_cyc0 = cyc;
        beat_cyc_last = cyc;
        cw = {cw[CWB0-2:0], bus0.m_data[0]};
        nbeats++;
        if (bus0.m_last) begin
          saw_last = 1;
          break;
        end
        if (nbeats >= stop_after || nbeats >= 2 * CWB0) break;
      end
      if (cyc > 2000) begin
        timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus0.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%0b exp=0", bus0.m_valid); end
    checks++; if (bus0.m_data !== '0) begin failures++; $display("[TB] FAIL reset_m_data got=%0h exp=0", bus0.m_data); end
    checks++; if (bus0.m_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_last got=%0b exp=0", bus0.m_last); end
    checks++; if (frame_err0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%0b exp=0", frame_err0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy0); end
    checks++; if (bus0.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready got=%0b exp=1", bus0.s_ready); end
    checks++; if (bus1.m_valid !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_wide got valid=%0b busy=%0b exp 0/0", bus1.m_valid, busy1); end
    rst_n = 1'b1;
  endtask

  task automatic test_unit_message();
    logic [CWB0-1:0] cw;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    run_frame0(7'b0000001, 100, 100, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cw !== 15'b0000001_11010001) begin failures++; $display("[TB] FAIL unit_codeword got=%b exp=%b", cw, 15'b0000001_11010001); end
    checks++; if (nb !== CWB0 || !sl || to) begin failures++; $display("[TB] FAIL unit_beats got=%0d last=%0b exp=%0d last=1", nb, sl, CWB0); end
    checks++; if (b0 - ac !== 1) begin failures++; $display("[TB] FAIL unit_latency got=%0d exp=1", b0 - ac); end
    checks++; if (bl - b0 !== CWB0 - 1) begin failures++; $display("[TB] FAIL unit_throughput got=%0d exp=%0d", bl - b0, CWB0 - 1); end
  endtask

  task automatic test_zero_and_linearity();
    logic [CWB0-1:0] cw, cwa, cwb, cwx;
    logic [K0-1:0]   a, b;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    run_frame0('0, 100, 100, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cw !== '0 || nb !== CWB0) begin failures++; $display("[TB] FAIL zero_codeword got=%b beats=%0d exp=0 beats=%0d", cw, nb, CWB0); end
    a = K0'($urandom);
    b = K0'($urandom);
    run_frame0(a, 100, 100, N_MSG0 - 1, -1, 1000, cwa, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cwa !== ref_cw0(a)) begin failures++; $display("[TB] FAIL lin_a got=%b exp=%b", cwa, ref_cw0(a)); end
    run_frame0(b, 100, 100, N_MSG0 - 1, -1, 1000, cwb, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cwb !== ref_cw0(b)) begin failures++; $display("[TB] FAIL lin_b got=%b exp=%b", cwb, ref_cw0(b)); end
    run_frame0(a ^ b, 100, 100, N_MSG0 - 1, -1, 1000, cwx, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cwx[PAR0-1:0] !== (cwa[PAR0-1:0] ^ cwb[PAR0-1:0])) begin failures++; $display("[TB] FAIL lin_parity got=%h exp=%h", cwx[PAR0-1:0], cwa[PAR0-1:0] ^ cwb[PAR0-1:0]); end
  endtask

  task automatic test_wide_word();
    logic [K1+PAR1-1:0] cw, expw;
    logic [K1-1:0]      msg;
    logic [2:0]         lasts;
    logic [63:0]        p;
    bus1.m_ready = 1'b1;
    for (int n = 0; n < 21; n++) begin
      msg = (n == 0) ? 5'b00001 : K1'($urandom);
      cw = '0;
      lasts = '0;
      @(negedge clk);
      checks++; if (bus1.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL wide_idle got=%0b exp=0", bus1.m_valid); end
      bus1.s_valid = 1'b1;
      bus1.s_data  = msg;
      bus1.s_last  = 1'b1;
      #1;
      checks++; if (bus1.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL wide_s_ready got=%0b exp=1", bus1.s_ready); end
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        bus1.s_valid = 1'b0;
        bus1.s_last  = 1'b0;
        checks++; if (bus1.m_valid !== 1'b1) begin failures++; $display("[TB] FAIL wide_valid beat=%0d got=%0b exp=1", b, bus1.m_valid); end
        cw = {cw[K1+PAR1-W1-1:0], bus1.m_data};
        lasts[b] = bus1.m_last;
      end
      p = ref_parity({59'b0, msg}, K1, PAR1, {54'b0, GEN1});
      expw = {msg, p[PAR1-1:0]};
      checks++; if (cw !== expw) begin failures++; $display("[TB] FAIL wide_codeword got=%b exp=%b", cw, expw); end
      checks++; if (lasts !== 3'b100) begin failures++; $display("[TB] FAIL wide_last got=%b exp=100", lasts); end
      if (n == 0) begin
        checks++; if (cw[PAR1-1:0] !== 10'h137) begin failures++; $display("[TB] FAIL wide_unit_parity got=%h exp=137", cw[PAR1-1:0]); end
      end
    end
  endtask

  task automatic test_random_backpressure();
    logic [CWB0-1:0] cw;
    logic [K0-1:0]   msg;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    for (int n = 0; n < 100; n++) begin
      msg = K0'($urandom);
      run_frame0(msg, 50, 75, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
      checks++; if (cw !== ref_cw0(msg)) begin failures++; $display("[TB] FAIL rand_codeword n=%0d got=%b exp=%b", n, cw, ref_cw0(msg)); end
      checks++; if (nb !== CWB0 || !sl || to) begin failures++; $display("[TB] FAIL rand_beats n=%0d got=%0d last=%0b timeout=%0b exp=%0d", n, nb, sl, to, CWB0); end
      checks++; if (sb !== 0) begin failures++; $display("[TB] FAIL rand_stall_stable n=%0d got=%0d exp=0", n, sb); end
    end
    checks++; if (frame_err0 !== 1'b0) begin failures++; $display("[TB] FAIL rand_frame_err got=%0b exp=0", frame_err0); end
  endtask

  task automatic test_frame_err();
    logic [CWB0-1:0] cw;
    logic [K0-1:0]   msg;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    msg = K0'($urandom);
    run_frame0(msg, 100, 100, 3, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (frame_err0 !== 1'b1) begin failures++; $display("[TB] FAIL ferr_set got=%0b exp=1", frame_err0); end
    checks++; if (cw !== ref_cw0(msg) || nb !== CWB0 || !sl) begin failures++; $display("[TB] FAIL ferr_codeword got=%b beats=%0d exp=%b beats=%0d", cw, nb, ref_cw0(msg), CWB0); end
    msg = K0'($urandom);
    run_frame0(msg, 100, 100, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (frame_err0 !== 1'b1) begin failures++; $display("[TB] FAIL ferr_sticky got=%0b exp=1", frame_err0); end
    checks++; if (cw !== ref_cw0(msg)) begin failures++; $display("[TB] FAIL ferr_next_codeword got=%b exp=%b", cw, ref_cw0(msg)); end
  endtask

  task automatic test_reset_mid();
    logic [CWB0-1:0] cw;
    logic [K0-1:0]   msg;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    msg = K0'($urandom);
    run_frame0(msg, 100, 100, N_MSG0 - 1, -1, 10, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (busy0 !== 1'b1 || nb !== 10) begin failures++; $display("[TB] FAIL mid_busy got=%0b beats=%0d exp=1 beats=10", busy0, nb); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.m_valid !== 1'b0 || bus0.m_last !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_valid got=%0b/%0b exp=0/0", bus0.m_valid, bus0.m_last); end
    checks++; if (frame_err0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_flags got=%0b/%0b exp=0/0", frame_err0, busy0); end
    @(negedge clk);
    bus0.s_valid = 1'b0;
    rst_n = 1'b1;
    msg = K0'($urandom);
    run_frame0(msg, 100, 100, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cw !== ref_cw0(msg) || nb !== CWB0 || !sl) begin failures++; $display("[TB] FAIL mid_after_reset got=%b beats=%0d exp=%b beats=%0d", cw, nb, ref_cw0(msg), CWB0); end
  endtask

`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
  task automatic test_err_inj();
    logic [CWB0-1:0] cw, expc;
    int nb, ac, b0, bl, sb;
    bit sl, to;
    run_frame0(7'b0000001, 100, 100, N_MSG0 - 1, 1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    inj_en0 = 1'b0;
    expc = 15'b0000001_11010001 ^ (15'b1 << (CWB0 - 2));
    checks++; if (cw !== expc || nb !== CWB0) begin failures++; $display("[TB] FAIL inj_codeword got=%b exp=%b", cw, expc); end
    run_frame0(7'b0000001, 100, 100, N_MSG0 - 1, -1, 1000, cw, nb, sl, ac, b0, bl, sb, to);
    checks++; if (cw !== 15'b0000001_11010001) begin failures++; $display("[TB] FAIL inj_clean_after got=%b exp=%b", cw, 15'b0000001_11010001); end
  endtask
`endif

  // Global bound so a stuck handshake cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus0.s_valid = 1'b0; bus0.s_data = '0; bus0.s_last = 1'b0; bus0.m_ready = 1'b0;
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.s_last = 1'b0; bus1.m_ready = 1'b0;
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
    inj_en0 = 1'b0; inj_mask0 = '0; inj_en1 = 1'b0; inj_mask1 = '0;
`endif
    test_reset();
    test_unit_message();
    test_zero_and_linearity();
    test_wide_word();
    test_random_backpressure();
    test_frame_err();
    test_reset_mid();
`ifdef VIP_BCH_ENCODER_ERR_INJ_EN
    test_err_inj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
